// File: rtl/redmule_stdio_axi_writer.sv
// AXI4 single-beat write initiator for console characters and the exit/EOC sequence.
// Optional macro STDIO_BRESP_CHECK_EN adds sticky B-response error tracking (err_o, err_cnt_o).
package redmule_stdio_axi_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic [0:0]  user;
    } axi_aw_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [0:0]  user;
    } axi_ar_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic [0:0]  user;
    } axi_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        logic [0:0] user;
    } axi_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  user;
    } axi_r_t;

    typedef struct packed {
        axi_aw_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_default_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_default_rsp_t;
endpackage

module redmule_stdio_axi_writer
    import redmule_stdio_axi_pkg::*;
#(
    parameter logic [31:0] STDOUT_ADDR = 32'h2FFF_0004,
    parameter logic [31:0] EXIT_ADDR   = 32'h2FFF_0000,
    parameter logic [31:0] EOC_ADDR    = 32'h2C03_0000,
    parameter logic [3:0]  AXI_ID      = 4'd0,
    parameter int          DATA_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             char_valid_i,
    output logic             char_ready_o,
    input  logic [7:0]       char_data_i,
    input  logic             exit_valid_i,
    output logic             exit_ready_o,
    input  logic [7:0]       exit_code_i,
    output axi_default_req_t axi_req_o,
    input  axi_default_rsp_t axi_rsp_i,
    output logic             done_o,
    output logic [31:0]      chars_sent_o,
    output logic             err_o,
    output logic [7:0]       err_cnt_o
);
    if (DATA_W != 32) begin : g_bad_data_w
        $fatal(1, "redmule_stdio_axi_writer: DATA_W must be 32");
    end

    typedef enum logic [1:0] {IDLE, SEND, WAIT_B, DONE} state_t;
    typedef enum logic [1:0] {KIND_CHAR, KIND_EXIT, KIND_EOC} kind_t;

    state_t      state_reg, state_next;
    kind_t       kind_reg, kind_next;
    logic [7:0]  data_reg, data_next;
    logic        aw_valid_reg, aw_valid_next;
    logic        w_valid_reg, w_valid_next;
    logic        b_ready_reg, b_ready_next;
    logic        aw_done_reg, aw_done_next;
    logic        w_done_reg, w_done_next;
    logic        exit_ready_reg, exit_ready_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        done_reg;
    logic [31:0] chars_sent_reg;

    logic aw_hs, w_hs, b_hs, send_stay;
    logic unused_rsp;

    assign aw_hs = aw_valid_reg & axi_rsp_i.aw_ready;
    assign w_hs  = w_valid_reg & axi_rsp_i.w_ready;
    assign b_hs  = b_ready_reg & axi_rsp_i.b_valid;
    assign unused_rsp = ^axi_rsp_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            kind_reg       <= KIND_CHAR;
            data_reg       <= '0;
            aw_valid_reg   <= 1'b0;
            w_valid_reg    <= 1'b0;
            b_ready_reg    <= 1'b0;
            aw_done_reg    <= 1'b0;
            w_done_reg     <= 1'b0;
            exit_ready_reg <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            done_reg       <= 1'b0;
            chars_sent_reg <= '0;
        end else begin
            state_reg      <= state_next;
            kind_reg       <= kind_next;
            data_reg       <= data_next;
            aw_valid_reg   <= aw_valid_next;
            w_valid_reg    <= w_valid_next;
            b_ready_reg    <= b_ready_next;
            aw_done_reg    <= aw_done_next;
            w_done_reg     <= w_done_next;
            exit_ready_reg <= exit_ready_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            if (b_hs && kind_reg == KIND_CHAR) chars_sent_reg <= chars_sent_reg + 32'd1;
            if (b_hs && kind_reg == KIND_EOC) done_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        kind_next  = kind_reg;
        data_next  = data_reg;
        unique case (state_reg)
            IDLE: begin
                if (char_valid_i) begin
                    data_next  = char_data_i;
                    kind_next  = KIND_CHAR;
                    state_next = SEND;
                end else if (exit_valid_i) begin
                    data_next  = exit_code_i;
                    kind_next  = KIND_EXIT;
                    state_next = SEND;
                end
            end
            SEND: begin
                if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) state_next = WAIT_B;
            end
            WAIT_B: begin
                if (axi_rsp_i.b_valid) begin
                    unique case (kind_reg)
                        KIND_CHAR: state_next = IDLE;
                        KIND_EXIT: begin
                            kind_next  = KIND_EOC;
                            state_next = SEND;
                        end
                        default:   state_next = DONE;
                    endcase
                end
            end
            default: state_next = DONE;
        endcase
    end

    // Completion flags survive only while the block remains in SEND; every SEND entry
    // therefore starts with both valids raised.
    always_comb begin
        send_stay       = (state_reg == SEND) && (state_next == SEND);
        aw_done_next    = send_stay ? (aw_done_reg | aw_hs) : 1'b0;
        w_done_next     = send_stay ? (w_done_reg | w_hs) : 1'b0;
        aw_valid_next   = (state_next == SEND) && !aw_done_next;
        w_valid_next    = (state_next == SEND) && !w_done_next;
        b_ready_next    = (state_next == WAIT_B);
        exit_ready_next = (state_reg == WAIT_B) && axi_rsp_i.b_valid && (kind_reg == KIND_EOC);
        unique case (kind_next)
            KIND_CHAR: begin
                addr_next  = STDOUT_ADDR;
                wdata_next = {24'h0, data_next};
            end
            KIND_EXIT: begin
                addr_next  = EXIT_ADDR;
                wdata_next = {24'h0, data_next};
            end
            default: begin
                addr_next  = EOC_ADDR;
                wdata_next = {1'b1, 23'h0, data_next};
            end
        endcase
    end

    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw.id    = AXI_ID;
        axi_req_o.aw.addr  = addr_reg;
        axi_req_o.aw.size  = 3'b010;
        axi_req_o.aw.burst = 2'b01;
        axi_req_o.aw_valid = aw_valid_reg;
        axi_req_o.w.data   = wdata_reg;
        axi_req_o.w.strb   = 4'hF;
        axi_req_o.w.last   = 1'b1;
        axi_req_o.w_valid  = w_valid_reg;
        axi_req_o.b_ready  = b_ready_reg;
    end

    assign char_ready_o = (state_reg == IDLE) && char_valid_i && !rst_i;
    assign exit_ready_o = exit_ready_reg;
    assign done_o       = done_reg;
    assign chars_sent_o = chars_sent_reg;

`ifdef STDIO_BRESP_CHECK_EN
    logic       err_reg;
    logic [7:0] err_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else if (b_hs && axi_rsp_i.b.resp != 2'b00) begin
            err_reg <= 1'b1;
            if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_o     = err_reg;
    assign err_cnt_o = err_cnt_reg;
`else
    assign err_o     = 1'b0;
    assign err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_redmule_stdio_axi_writer.sv
// Randomized self-checking bench for redmule_stdio_axi_writer with a queue-based
// expected-write model and a configurable AXI slave.
module tb_redmule_stdio_axi_writer;
    import redmule_stdio_axi_pkg::*;

    localparam logic [31:0] STDOUT_A = 32'h2FFF_0004;
    localparam logic [31:0] EXIT_A   = 32'h2FFF_0000;
    localparam logic [31:0] EOC_A    = 32'h2C03_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          ok;
        int          awc;
        int          wc;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             char_valid = 1'b0;
    logic [7:0]       char_data = 8'h0;
    logic             exit_valid = 1'b0;
    logic [7:0]       exit_code = 8'h0;
    logic             char_ready, exit_ready, done, err;
    logic [31:0]      chars_sent;
    logic [7:0]       err_cnt;
    axi_default_req_t req;
    axi_default_rsp_t rsp;

    int checks = 0;
    int passed = 0;
    int exp_chars = 0;
    wr_t cap_q[$];
    wr_t exp_q[$];
    int  aw_cyc_q[$];

    // slave configuration and state
    int aw_hold = 1, w_hold = 1, b_delay = 0;
    logic [1:0] b_resp = 2'b00;
    int aw_cnt = 0, w_cnt = 0, b_wait = 0, cyc = 0, stab_err = 0, ar_err = 0;
    bit aw_got = 0, w_got = 0, b_pend = 0, b_valid_s = 0;
    bit prev_aw_wait = 0, prev_w_wait = 0, cap_awok = 0, cap_wok = 0;
    logic [31:0] cap_addr = 0, cap_data = 0, prev_addr = 0, prev_data = 0;
    int cap_awc = 0, cap_wc = 0;

    always #5 clk = ~clk;

    redmule_stdio_axi_writer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .char_valid_i (char_valid),
        .char_ready_o (char_ready),
        .char_data_i  (char_data),
        .exit_valid_i (exit_valid),
        .exit_ready_o (exit_ready),
        .exit_code_i  (exit_code),
        .axi_req_o    (req),
        .axi_rsp_i    (rsp),
        .done_o       (done),
        .chars_sent_o (chars_sent),
        .err_o        (err),
        .err_cnt_o    (err_cnt)
    );

    always_comb begin
        rsp          = '0;
        rsp.aw_ready = req.aw_valid && (aw_cnt >= aw_hold - 1);
        rsp.w_ready  = req.w_valid && (w_cnt >= w_hold - 1);
        rsp.b_valid  = b_valid_s;
        rsp.b.resp   = b_resp;
    end

    always @(posedge clk) begin : slave
        bit  aw_hs, w_hs, aw_now, w_now, awok, wok;
        wr_t e;
        cyc <= cyc + 1;
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 0; w_got <= 0;
            b_valid_s <= 0; b_pend <= 0; prev_aw_wait <= 0; prev_w_wait <= 0;
        end else begin
            aw_hs = req.aw_valid && rsp.aw_ready;
            w_hs  = req.w_valid && rsp.w_ready;
            awok  = req.aw.id == 0 && req.aw.len == 0 && req.aw.size == 3'b010 && req.aw.burst == 2'b01
                    && req.aw.lock == 0 && req.aw.cache == 0 && req.aw.prot == 0 && req.aw.qos == 0
                    && req.aw.region == 0 && req.aw.atop == 0 && req.aw.user == 0;
            wok   = req.w.strb == 4'hF && req.w.last == 1'b1;
            if (req.ar_valid || req.r_ready) ar_err <= ar_err + 1;
            if ((prev_aw_wait && (!req.aw_valid || req.aw.addr !== prev_addr)) ||
                (prev_w_wait && (!req.w_valid || req.w.data !== prev_data)))
                stab_err <= stab_err + 1;
            prev_aw_wait <= req.aw_valid && !rsp.aw_ready;
            prev_w_wait  <= req.w_valid && !rsp.w_ready;
            prev_addr    <= req.aw.addr;
            prev_data    <= req.w.data;
            if (req.aw_valid) aw_cnt <= aw_hs ? 0 : aw_cnt + 1;
            if (req.w_valid) w_cnt <= w_hs ? 0 : w_cnt + 1;
            if (aw_hs) begin
                cap_addr <= req.aw.addr; cap_awc <= aw_cnt + 1; cap_awok <= awok; aw_got <= 1;
                aw_cyc_q.push_back(cyc);
            end
            if (w_hs) begin
                cap_data <= req.w.data; cap_wc <= w_cnt + 1; cap_wok <= wok; w_got <= 1;
            end
            aw_now = aw_got || aw_hs;
            w_now  = w_got || w_hs;
            if (aw_now && w_now) begin
                e.addr = aw_hs ? req.aw.addr : cap_addr;
                e.awc  = aw_hs ? aw_cnt + 1 : cap_awc;
                e.data = w_hs ? req.w.data : cap_data;
                e.wc   = w_hs ? w_cnt + 1 : cap_wc;
                e.ok   = (aw_hs ? awok : cap_awok) && (w_hs ? wok : cap_wok);
                cap_q.push_back(e);
                aw_got <= 0; w_got <= 0;
                if (b_delay == 0) b_valid_s <= 1;
                else begin b_pend <= 1; b_wait <= b_delay; end
            end
            if (b_pend) begin
                if (b_wait <= 1) begin b_valid_s <= 1; b_pend <= 0; end
                else b_wait <= b_wait - 1;
            end
            if (b_valid_s && req.b_ready) b_valid_s <= 0;
        end
    end

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a; e.data = d; e.ok = 1; e.awc = 0; e.wc = 0;
        exp_q.push_back(e);
    endtask

    task automatic send_char(input logic [7:0] c, output bit ok);
        @(negedge clk);
        char_valid = 1'b1;
        char_data  = c;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (char_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        char_valid = 1'b0;
    endtask

    task automatic wait_sent(input int target, output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (chars_sent == target) begin ok = 1; break; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_chars = 0;
        cap_q.delete(); exp_q.delete(); aw_cyc_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; char_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (req.aw_valid !== 1'b0 || req.w_valid !== 1'b0) $display("FAIL reset_valids: got aw=%b w=%b want 0 0", req.aw_valid, req.w_valid); else passed++;
        checks++; if (req.b_ready !== 1'b0 || req.ar_valid !== 1'b0 || req.r_ready !== 1'b0) $display("FAIL reset_readies: got b_ready=%b ar_valid=%b r_ready=%b want 0", req.b_ready, req.ar_valid, req.r_ready); else passed++;
        checks++; if (done !== 1'b0 || exit_ready !== 1'b0) $display("FAIL reset_done: got done=%b exit_ready=%b want 0 0", done, exit_ready); else passed++;
        checks++; if (chars_sent !== 32'd0) $display("FAIL reset_chars_sent: got %0d want 0", chars_sent); else passed++;
        checks++; if (err !== 1'b0 || err_cnt !== 8'd0) $display("FAIL reset_err: got err=%b cnt=%0d want 0 0", err, err_cnt); else passed++;
        checks++; if (char_ready !== 1'b0) $display("FAIL reset_char_ready_in_reset: got %b want 0", char_ready); else passed++;
        char_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (char_ready !== 1'b0) $display("FAIL reset_char_ready_idle: got %b want 0", char_ready); else passed++;
        $display("test_reset done");
    endtask

    task automatic test_hi();
        bit ok1, ok2, ok3;
        aw_hold = 1; w_hold = 1; b_delay = 0;
        cap_q.delete(); exp_q.delete(); aw_cyc_q.delete();
        send_char(8'h48, ok1); expect_write(STDOUT_A, 32'h48); exp_chars++;
        send_char(8'h69, ok2); expect_write(STDOUT_A, 32'h69); exp_chars++;
        wait_sent(exp_chars, ok3);
        checks++; if (!(ok1 && ok2 && ok3)) $display("FAIL hi_timeout: got accept=%b%b sent=%b want 111", ok1, ok2, ok3); else passed++;
        checks++; if (cap_q.size() != exp_q.size()) $display("FAIL hi_count: got %0d writes want %0d", cap_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i].addr !== exp_q[i].addr || cap_q[i].data !== exp_q[i].data || !cap_q[i].ok)
                $display("FAIL hi_write[%0d]: got addr=%h data=%h fields_ok=%0d want addr=%h data=%h", i, cap_q[i].addr, cap_q[i].data, cap_q[i].ok, exp_q[i].addr, exp_q[i].data);
            else passed++;
        end
        checks++; if (chars_sent !== 32'd2) $display("FAIL hi_chars_sent: got %0d want 2", chars_sent); else passed++;
        checks++; if (aw_cyc_q.size() != 2 || aw_cyc_q[1] - aw_cyc_q[0] != 3) $display("FAIL hi_spacing: got %0d aw beats spacing %0d want 2 beats spacing 3", aw_cyc_q.size(), (aw_cyc_q.size() > 1) ? aw_cyc_q[1] - aw_cyc_q[0] : -1); else passed++;
        $display("test_hi: %0d writes, chars_sent=%0d", cap_q.size(), chars_sent);
    endtask

    task automatic test_aw_delay();
        bit ok1, ok2;
        aw_hold = 4; w_hold = 1; b_delay = 0;
        cap_q.delete(); exp_q.delete();
        send_char(8'h41, ok1); expect_write(STDOUT_A, 32'h41); exp_chars++;
        wait_sent(exp_chars, ok2);
        checks++; if (!(ok1 && ok2) || cap_q.size() != 1) $display("FAIL awdelay_done: got accept=%b sent=%b writes=%0d want 1 1 1", ok1, ok2, cap_q.size()); else passed++;
        if (cap_q.size() == 1) begin
            checks++; if (cap_q[0].awc != 4 || cap_q[0].wc != 1) $display("FAIL awdelay_valid_cycles: got aw=%0d w=%0d want aw=4 w=1", cap_q[0].awc, cap_q[0].wc); else passed++;
            checks++; if (cap_q[0].addr !== STDOUT_A || cap_q[0].data !== 32'h41) $display("FAIL awdelay_payload: got addr=%h data=%h want %h 00000041", cap_q[0].addr, cap_q[0].data, STDOUT_A); else passed++;
        end
        checks++; if (stab_err != 0) $display("FAIL awdelay_stability: got %0d violations want 0", stab_err); else passed++;
        checks++; if (chars_sent !== exp_chars) $display("FAIL awdelay_single_b: got chars_sent=%0d want %0d", chars_sent, exp_chars); else passed++;
        aw_hold = 1;
        $display("test_aw_delay: aw cycles=%0d", (cap_q.size() > 0) ? cap_q[0].awc : -1);
    endtask

    task automatic test_random_chars();
        bit ok1, ok2, all_ok;
        logic [7:0] c;
        cap_q.delete(); exp_q.delete();
        all_ok = 1;
        for (int n = 0; n < 12; n++) begin
            aw_hold = $urandom_range(1, 3); w_hold = $urandom_range(1, 3); b_delay = $urandom_range(0, 2);
            c = 8'($urandom);
            send_char(c, ok1); expect_write(STDOUT_A, {24'h0, c}); exp_chars++;
            wait_sent(exp_chars, ok2);
            all_ok = all_ok && ok1 && ok2;
        end
        checks++; if (!all_ok) $display("FAIL random_timeout: got incomplete transfers want all complete"); else passed++;
        checks++; if (cap_q.size() != exp_q.size()) $display("FAIL random_count: got %0d writes want %0d", cap_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i].addr !== exp_q[i].addr || cap_q[i].data !== exp_q[i].data || !cap_q[i].ok)
                $display("FAIL random_write[%0d]: got addr=%h data=%h fields_ok=%0d want addr=%h data=%h", i, cap_q[i].addr, cap_q[i].data, cap_q[i].ok, exp_q[i].addr, exp_q[i].data);
            else passed++;
        end
        checks++; if (stab_err != 0) $display("FAIL random_stability: got %0d violations want 0", stab_err); else passed++;
        aw_hold = 1; w_hold = 1; b_delay = 0;
        $display("test_random_chars: %0d writes, chars_sent=%0d", cap_q.size(), chars_sent);
    endtask

    task automatic test_bresp();
        bit ok1, ok2;
        logic       exp_err;
        logic [7:0] exp_cnt;
`ifdef STDIO_BRESP_CHECK_EN
        exp_err = 1'b1; exp_cnt = 8'd1;
`else
        exp_err = 1'b0; exp_cnt = 8'd0;
`endif
        b_resp = 2'b10;
        send_char(8'h45, ok1); exp_chars++;
        wait_sent(exp_chars, ok2);
        b_resp = 2'b00;
        checks++; if (!(ok1 && ok2)) $display("FAIL bresp_complete: got accept=%b sent=%b want 1 1", ok1, ok2); else passed++;
        checks++; if (err !== exp_err || err_cnt !== exp_cnt) $display("FAIL bresp_err: got err=%b cnt=%0d want err=%b cnt=%0d", err, err_cnt, exp_err, exp_cnt); else passed++;
        send_char(8'h46, ok1); exp_chars++;
        wait_sent(exp_chars, ok2);
        checks++; if (err !== exp_err || err_cnt !== exp_cnt || chars_sent !== exp_chars) $display("FAIL bresp_sticky: got err=%b cnt=%0d sent=%0d want err=%b cnt=%0d sent=%0d", err, err_cnt, chars_sent, exp_err, exp_cnt, exp_chars); else passed++;
        $display("test_bresp: err=%b err_cnt=%0d chars_sent=%0d", err, err_cnt, chars_sent);
    endtask

    task automatic test_reset_mid();
        bit ok1, seen;
        b_delay = 6;
        send_char(8'h52, ok1);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req.b_ready) begin seen = 1; break; end
        end
        checks++; if (!(ok1 && seen)) $display("FAIL rstmid_reach_wait_b: got accept=%b b_ready_seen=%b want 1 1", ok1, seen); else passed++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (req.aw_valid !== 1'b0 || req.w_valid !== 1'b0 || req.b_ready !== 1'b0) $display("FAIL rstmid_valids: got aw=%b w=%b b_ready=%b want 0 0 0", req.aw_valid, req.w_valid, req.b_ready); else passed++;
        checks++; if (chars_sent !== 32'd0) $display("FAIL rstmid_chars_sent: got %0d want 0", chars_sent); else passed++;
        @(negedge clk);
        rst = 1'b0; exp_chars = 0;
        char_valid = 1'b1; char_data = 8'h33;
        #1;
        checks++; if (char_ready !== 1'b1) $display("FAIL rstmid_ready_follows_high: got %b want 1", char_ready); else passed++;
        char_valid = 1'b0;
        #1;
        checks++; if (char_ready !== 1'b0) $display("FAIL rstmid_ready_follows_low: got %b want 0", char_ready); else passed++;
        repeat (10) @(negedge clk);
        checks++; if (chars_sent !== 32'd0 || req.b_ready !== 1'b0) $display("FAIL rstmid_no_stale_b: got chars_sent=%0d b_ready=%b want 0 0", chars_sent, req.b_ready); else passed++;
        b_delay = 0;
        cap_q.delete(); exp_q.delete(); aw_cyc_q.delete();
        $display("test_reset_mid: chars_sent=%0d after reset", chars_sent);
    endtask

    task automatic test_simultaneous();
        bit ok;
        int pulses;
        logic [7:0] c, code;
        c = 8'($urandom); code = 8'($urandom);
        cap_q.delete(); exp_q.delete();
        @(negedge clk);
        char_valid = 1'b1; char_data = c; exit_valid = 1'b1; exit_code = code;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (char_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (ok) begin @(posedge clk); #1; end
        char_valid = 1'b0;
        expect_write(STDOUT_A, {24'h0, c}); exp_chars++;
        expect_write(EXIT_A, {24'h0, code});
        expect_write(EOC_A, {1'b1, 23'h0, code});
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (exit_ready) begin pulses++; exit_valid = 1'b0; end
        end
        exit_valid = 1'b0;
        checks++; if (!ok) $display("FAIL simul_char_first: got char_ready=0 want 1"); else passed++;
        checks++; if (pulses != 1 || done !== 1'b1) $display("FAIL simul_exit: got pulses=%0d done=%b want 1 1", pulses, done); else passed++;
        checks++; if (chars_sent !== exp_chars) $display("FAIL simul_chars_sent: got %0d want %0d", chars_sent, exp_chars); else passed++;
        checks++; if (cap_q.size() != exp_q.size()) $display("FAIL simul_count: got %0d writes want %0d", cap_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i].addr !== exp_q[i].addr || cap_q[i].data !== exp_q[i].data || !cap_q[i].ok)
                $display("FAIL simul_write[%0d]: got addr=%h data=%h fields_ok=%0d want addr=%h data=%h", i, cap_q[i].addr, cap_q[i].data, cap_q[i].ok, exp_q[i].addr, exp_q[i].data);
            else passed++;
        end
        $display("test_simultaneous: %0d writes, pulses=%0d", cap_q.size(), pulses);
    endtask

    task automatic test_exit();
        bit started;
        int pulses, readies, beats;
        do_reset();
        @(negedge clk);
        exit_valid = 1'b1; exit_code = 8'h05;
        started = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req.aw_valid) begin started = 1; break; end
        end
        char_valid = 1'b1; char_data = 8'h4C;
        expect_write(EXIT_A, 32'h0000_0005);
        expect_write(EOC_A, 32'h8000_0005);
        pulses = 0; readies = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (char_ready) readies++;
            @(negedge clk);
            if (exit_ready) begin pulses++; exit_valid = 1'b0; end
        end
        exit_valid = 1'b0;
        beats = aw_cyc_q.size();
        repeat (10) @(negedge clk);
        checks++; if (!started) $display("FAIL exit_start: got no aw_valid want aw_valid"); else passed++;
        checks++; if (pulses != 1) $display("FAIL exit_pulse: got %0d pulses want 1", pulses); else passed++;
        checks++; if (done !== 1'b1) $display("FAIL exit_done: got %b want 1", done); else passed++;
        checks++; if (readies != 0 || char_ready !== 1'b0) $display("FAIL exit_late_char: got %0d ready cycles want 0", readies); else passed++;
        checks++; if (aw_cyc_q.size() != beats || beats != 2) $display("FAIL exit_no_more_traffic: got %0d aw beats want 2", aw_cyc_q.size()); else passed++;
        checks++; if (chars_sent !== 32'd0) $display("FAIL exit_chars_sent: got %0d want 0", chars_sent); else passed++;
        checks++; if (cap_q.size() != exp_q.size()) $display("FAIL exit_count: got %0d writes want %0d", cap_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i].addr !== exp_q[i].addr || cap_q[i].data !== exp_q[i].data || !cap_q[i].ok)
                $display("FAIL exit_write[%0d]: got addr=%h data=%h fields_ok=%0d want addr=%h data=%h", i, cap_q[i].addr, cap_q[i].data, cap_q[i].ok, exp_q[i].addr, exp_q[i].data);
            else passed++;
        end
        checks++; if (ar_err != 0) $display("FAIL read_channel_idle: got %0d cycles with ar_valid/r_ready want 0", ar_err); else passed++;
        char_valid = 1'b0;
        $display("test_exit: %0d writes, pulses=%0d, done=%b", cap_q.size(), pulses, done);
    endtask

    initial begin
        test_reset();
        test_hi();
        test_aw_delay();
        test_random_chars();
        test_bresp();
        test_reset_mid();
        test_simultaneous();
        test_exit();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end
endmodule
